// File: rtl/glue_pkg.sv
// Shared types and the golden model of the four-output glue block.
package glue_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  typedef logic [3:0] vec_t;

  localparam vec_t LAST_VEC = 4'd15;

  // Expected {OUT7,OUT6,OUT5,OUT4} for input vector {IN7,IN6,IN5,IN4}.
  function automatic logic [3:0] glue_expect(vec_t v);
    logic [3:0] o;
    o[0] = (v[0] & v[1]) | ~v[2];
    o[1] = v[0] | v[1];
    o[2] = v[0] ^ v[1];
    o[3] = (v[2] == v[3]);
    return o;
  endfunction

endpackage

// File: rtl/glue_settle_timer.sv
// Counts selected-timebase strobes after a vector is applied and flags when
// the settle time has elapsed. The unselected strobe is ignored.
module glue_settle_timer #(
  parameter int unsigned SETTLE_TICKS = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sel_i,
  input  logic tick_1mhz_i,
  input  logic tick_1hz_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CW = (SETTLE_TICKS < 2) ? 1 : $clog2(SETTLE_TICKS + 1);
  localparam logic [CW-1:0] TARGET    = CW'(SETTLE_TICKS);
  localparam logic [CW-1:0] TARGET_M1 = CW'((SETTLE_TICKS == 0) ? 0 : SETTLE_TICKS - 1);
  localparam bit            HAS_TICKS = (SETTLE_TICKS != 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick;

  assign tick = sel_i ? tick_1mhz_i : tick_1hz_i;

  // Expire as soon as the last required strobe arrives, or at once with no ticks.
  assign expire_o = enable_i &&
                    ((cnt_q == TARGET) || (HAS_TICKS && tick && (cnt_q == TARGET_M1)));

  // Next count: clear wins so a strobe in the APPLY cycle is never counted.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && tick && (cnt_q != TARGET)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Strobe counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/glue_selftest_seq.sv
// Self-test sequencer: sweeps all 16 glue input vectors, waits a settle time
// per vector, compares against the golden model and reports the result.
module glue_selftest_seq
  import glue_pkg::*;
#(
  parameter int unsigned SETTLE_TICKS = 2,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clk_1mhz_i,
  input  logic       clk_1hz_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       speed_sel_i,
  input  logic [3:0] glue_out_i,
  output logic [3:0] glue_in_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [4:0] err_count_o,
  output logic [3:0] first_fail_o
);

  state_e     state_q;
  vec_t       vec_q;
  logic       speed_q;
  logic [3:0] glue_in_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [4:0] err_q;
  logic [4:0] err_d;
  vec_t       ff_q;
  logic       mismatch;
  logic       expire;

  glue_settle_timer #(
    .SETTLE_TICKS(SETTLE_TICKS)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .sel_i      (speed_q),
    .tick_1mhz_i(clk_1mhz_i),
    .tick_1hz_i (clk_1hz_i),
    .clear_i    (state_q == APPLY),
    .enable_i   (state_q == SETTLE),
    .expire_o   (expire)
  );

  assign mismatch = (glue_out_i != glue_expect(vec_q));

  // Error count as it will stand after the current CHECK cycle.
  always_comb begin
    err_d = err_q;
    if (mismatch) begin
      err_d = err_q + 5'd1;
    end
  end

  // Sweep FSM with registered outputs and result registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      speed_q   <= 1'b0;
      glue_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ff_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            speed_q   <= speed_sel_i;
            err_q     <= '0;
            ff_q      <= '0;
            pass_q    <= 1'b0;
            vec_q     <= '0;
            glue_in_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= APPLY;
          end
        end
        APPLY, SETTLE: begin
          if (abort_i) begin
            glue_in_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (state_q == APPLY) begin
            state_q <= SETTLE;
          end else if (expire) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (abort_i) begin
            glue_in_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            err_q <= err_d;
            if (mismatch && (err_q == 5'd0)) begin
              ff_q <= vec_q;
            end
            if ((vec_q == LAST_VEC) || (STOP_ON_FAIL && mismatch)) begin
              glue_in_q <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              pass_q    <= (err_d == 5'd0);
              state_q   <= DONE;
            end else begin
              vec_q     <= vec_q + 4'd1;
              glue_in_q <= vec_q + 4'd1;
              state_q   <= APPLY;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign glue_in_o    = glue_in_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_count_o  = err_q;
  assign first_fail_o = ff_q;

endmodule
